// File: rtl/reg_pipe_pkg.sv
// ---------------------------------------------------------------------------
// reg_pipe_pkg
// Shared helpers for the reg_pipe register pipeline:
//   count_width()  - number of bits needed to hold an occupancy of 0..depth
//   even_parity()  - even-parity bit of a value (XOR of all bits)
// Optional feature macro used by the files importing this package:
//   REG_PIPE_PARITY_EN - carry a parity bit with every pipeline entry
// ---------------------------------------------------------------------------
package reg_pipe_pkg;

    // Widest data word even_parity() accepts; narrower words are zero-extended
    // by the caller, which leaves the XOR result unchanged.
    localparam int PARITY_MAX_W = 64;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// ---------------------------------------------------------------------------
// reg_pipe_stage
// One slot of the reg_pipe pipeline: a valid bit, a data word and (with
// REG_PIPE_PARITY_EN defined) a parity bit travelling with the data.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high; clears valid, data and parity
//   flush       synchronous discard of the held entry (data kept)
//   load        capture load_data/load_parity as a new valid entry
//   advance     the held entry leaves this slot this cycle
//   load_data   data captured on load
//   load_parity parity captured on load        (REG_PIPE_PARITY_EN only)
//   valid       slot holds an entry
//   data        held data word
//   parity      held parity bit                 (REG_PIPE_PARITY_EN only)
// ---------------------------------------------------------------------------
module reg_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] load_data,
`ifdef REG_PIPE_PARITY_EN
    input  logic             load_parity,
    output logic             parity,
`endif
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // A load in the same cycle as an advance means the slot is refilled, so
    // load takes precedence over emptying. Data only changes on load so an
    // empty slot keeps its last word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (reset) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (advance) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        data_q  <= data_d;
    end

    assign valid = valid_q;
    assign data  = data_q;

`ifdef REG_PIPE_PARITY_EN
    logic parity_d, parity_q;

    always_comb begin
        parity_d = parity_q;
        if (reset) begin
            parity_d = 1'b0;
        end else if (!flush && load) begin
            parity_d = load_parity;
        end
    end

    always_ff @(posedge clk) begin
        parity_q <= parity_d;
    end

    assign parity = parity_q;
`endif

endmodule

// File: rtl/reg_pipe.sv
// ---------------------------------------------------------------------------
// reg_pipe
// DEPTH-stage valid/ready register pipeline with bubble collapse, flush and
// an occupancy counter. Stage 0 is the input side, stage DEPTH-1 drives the
// outputs. Optional macro REG_PIPE_PARITY_EN adds a per-entry even-parity
// bit and a parity mismatch flag at the output; without it parity_err is 0.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (highest priority)
//   flush      synchronous discard of all held entries
//   in_valid   upstream data valid
//   in_data    upstream data [WIDTH]
//   in_ready   pipeline accepts in_data this cycle (combinational)
//   out_valid  output stage holds an entry
//   out_data   output stage data [WIDTH]
//   out_ready  downstream accepts this cycle
//   count      occupied stages [count_width(DEPTH)]
//   parity_err output entry parity mismatch
// ---------------------------------------------------------------------------
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          parity_err
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] stage_adv;
    logic [DEPTH-1:0] stage_load;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic             push;
    logic             pop;
    logic [CW-1:0]    count_d, count_q;

    // Advance chains back from the output: the last stage moves when the
    // downstream takes it, an earlier stage moves when the next one is empty
    // or itself moving, so bubbles collapse within one cycle. in_ready is
    // therefore combinational from out_ready. During flush nothing moves
    // between stages and nothing is accepted; reset also blocks acceptance.
    always_comb begin
        stage_adv  = '0;
        stage_load = '0;
        stage_adv[DEPTH-1] = out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            stage_adv[k] = !stage_valid[k+1] || stage_adv[k+1];
        end
        in_ready = (!stage_valid[0] || stage_adv[0]) && !flush && !reset;
        push     = in_valid && in_ready;
        pop      = stage_valid[DEPTH-1] && out_ready;
        stage_load[0] = push;
        for (int k = 1; k < DEPTH; k++) begin
            stage_load[k] = stage_valid[k-1] && stage_adv[k-1] && !flush;
        end
    end

`ifdef REG_PIPE_PARITY_EN
    logic [DEPTH-1:0]        stage_parity;
    logic [PARITY_MAX_W-1:0] in_ext;
    logic [PARITY_MAX_W-1:0] out_ext;
    logic                    in_parity;

    // Parity is computed once at acceptance and then only carried, so a
    // corrupted stored bit shows up as a mismatch at the output.
    always_comb begin
        in_ext  = '0;
        out_ext = '0;
        in_ext[WIDTH-1:0]  = in_data;
        out_ext[WIDTH-1:0] = stage_data[DEPTH-1];
        in_parity  = even_parity(in_ext);
        parity_err = stage_valid[DEPTH-1] &&
                     (stage_parity[DEPTH-1] != even_parity(out_ext));
    end
`else
    assign parity_err = 1'b0;
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] load_data;
`ifdef REG_PIPE_PARITY_EN
        logic             load_parity;
        if (k == 0) begin : g_first
            assign load_data   = in_data;
            assign load_parity = in_parity;
        end else begin : g_next
            assign load_data   = stage_data[k-1];
            assign load_parity = stage_parity[k-1];
        end
`else
        if (k == 0) begin : g_first
            assign load_data = in_data;
        end else begin : g_next
            assign load_data = stage_data[k-1];
        end
`endif

        reg_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .load       (stage_load[k]),
            .advance    (stage_adv[k]),
            .load_data  (load_data),
`ifdef REG_PIPE_PARITY_EN
            .load_parity(load_parity),
            .parity     (stage_parity[k]),
`endif
            .valid      (stage_valid[k]),
            .data       (stage_data[k])
        );
    end

    // Occupancy follows push/pop; flush empties the pipe even if an entry
    // is delivered on that same edge.
    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        if (reset || flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count     = count_q;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, data bits per stage (>=1).
REQ-002 The block SHALL expose parameter DEPTH, default 3, number of register stages (>=1).
REQ-003 The block SHALL expose port clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL expose port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 The block SHALL expose port flush  input  1  synchronous discard of all held entries.
REQ-006 The block SHALL expose port in_valid  input  1  upstream data valid.
REQ-007 The block SHALL expose port in_data  input  WIDTH  upstream data.
REQ-008 The block SHALL expose port in_ready  output  1  block accepts in_data this cycle.
REQ-009 The block SHALL expose port out_valid  output  1  output stage holds an entry.
REQ-010 The block SHALL expose port out_data  output  WIDTH  output stage data, registered.
REQ-011 The block SHALL expose port out_ready  input  1  downstream accepts this cycle.
REQ-012 The block SHALL expose port count  output  $clog2(DEPTH+1)  number of occupied stages, registered.
REQ-013 The block SHALL expose port parity_err  output  1  output-entry parity mismatch flag.

Function
REQ-014 Stage k (0..DEPTH-1) SHALL hold one valid bit and WIDTH data bits; stage 0 is input side, stage DEPTH-1 drives out_valid/out_data.
REQ-015 Transfer SHALL occur on a rising clk where valid and ready are both high, on each side independently.
REQ-016 Stage DEPTH-1 SHALL advance when out_ready is high; stage k<DEPTH-1 SHALL advance when stage k+1 is empty or advancing (bubble collapse).
REQ-017 in_ready SHALL equal (stage 0 empty or stage 0 advancing) and not flush; it is combinational from out_ready.
REQ-018 An entry accepted into an empty pipe SHALL appear at out_valid exactly DEPTH cycles after acceptance with no back-pressure.
REQ-019 Order SHALL be preserved; no entry is lost or duplicated; out_data SHALL hold steady while out_valid high and out_ready low.
REQ-020 With out_ready held high and in_valid held high the block SHALL sustain one transfer per cycle.
REQ-021 Full (count==DEPTH) with out_ready low SHALL drive in_ready low; simultaneous pop and push when full SHALL be accepted, count unchanged.
REQ-022 count SHALL update each cycle as count + push - pop, never exceeding DEPTH or going below 0.
REQ-023 flush high SHALL clear all valid bits and count to 0 on that edge; any in_valid that cycle is not accepted; an out transfer that cycle counts as delivered.
REQ-024 Data registers of empty stages SHALL keep their last value (no toggling required).

Reset
REQ-025 reset SHALL have priority over flush and handshakes.
REQ-026 On reset all valid bits, all data registers, count, out_valid, out_data and parity_err SHALL be 0 after the edge.
REQ-027 Reset mid-stream SHALL discard all entries; in_ready SHALL be low during the reset cycle and high the first cycle after.

Configuration
REQ-028 With macro REG_PIPE_PARITY_EN defined, each stage SHALL store an extra even-parity bit computed from in_data at acceptance and carried with the entry.
REQ-029 With REG_PIPE_PARITY_EN defined, parity_err SHALL be high when out_valid is high and the stored parity differs from the XOR of out_data.
REQ-030 Without REG_PIPE_PARITY_EN, parity_err SHALL be tied to 0 and no parity storage synthesised; the port list is unchanged.

Structure
REQ-031 Package reg_pipe_pkg SHALL hold the even-parity function and the count-width constant function.
REQ-032 One sub-module reg_pipe_stage (valid bit, data, optional parity, load/hold control) SHALL be instantiated DEPTH times in a generate loop.

Verification
REQ-033 Reset then idle: count=0, out_valid=0, in_ready=1, parity_err=0.
REQ-034 DEPTH=3, out_ready=1, push 0xA5 at cycle 0: out_valid=1, out_data=0xA5 at cycle 3 only.
REQ-035 out_ready=0, push 0x01,0x02,0x03,0x04: first three accepted, count=3, in_ready=0 on fourth; raise out_ready: output 01,02,03 in order.
REQ-036 Full, out_ready=1 and in_valid=1 with 0x55 same cycle: pop accepted, push accepted, count stays 3.
REQ-037 count=2, assert flush one cycle with in_valid=1: count=0, out_valid=0 next cycle, pushed value never emerges.
REQ-038 REG_PIPE_PARITY_EN defined, force stored parity bit of 0x07 inverted: parity_err=1 while that entry is at output, 0 otherwise.
